// File: rtl/exu_seq.sv
// exu_seq: multi-cycle FETCH/WAIT/EXEC/WB sequencer that feeds the EXU and writes
// addi results to the GPR file. Optional fetch watchdog enabled by NPC_FETCH_TIMEOUT_EN.
module exu_seq #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_inst_req_valid,
  input  logic        i_inst_req_ready,
  output logic [31:0] o_inst_addr,
  input  logic        i_inst_rsp_valid,
  input  logic [31:0] i_inst_rdata,
  output logic [4:0]  o_rf_raddr,
  input  logic [31:0] i_rf_rdata,
  output logic [6:0]  o_ex_op,
  output logic [2:0]  o_ex_funct3,
  output logic [11:0] o_ex_imm,
  output logic [31:0] o_ex_src1,
  input  logic [31:0] i_ex_result,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instret,
  output logic        o_halt,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [6:0]  OP_IMM      = 7'b0010011;

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_instret;
  logic        r_halt;
  logic        r_err;
  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;

  logic        w_is_addi;
  logic        w_is_ebreak;
  logic        w_set_halt;
  logic        w_set_err;
  logic        w_timeout;

  assign w_is_addi   = (r_inst[6:0] == OP_IMM) && (r_inst[14:12] == 3'b000);
  assign w_is_ebreak = (r_inst == EBREAK_INST);

`ifdef NPC_FETCH_TIMEOUT_EN
  // Counts cycles spent in FETCH+WAIT for the current instruction; cleared on WB->FETCH.
  logic [31:0] r_tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (r_state == S_WB) begin
      r_tcnt <= '0;
    end else if ((r_state == S_FETCH) || (r_state == S_WAIT)) begin
      r_tcnt <= r_tcnt + 32'd1;
    end
  end

  assign w_timeout = (r_tcnt >= 32'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_set_halt   = 1'b0;
    w_set_err    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        if (i_inst_req_ready) begin
          w_next_state = S_WAIT;
        end else if (w_timeout) begin
          w_next_state = S_HALT;
          w_set_halt   = 1'b1;
          w_set_err    = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_inst_rsp_valid) begin
          w_next_state = S_EXEC;
        end else if (w_timeout) begin
          w_next_state = S_HALT;
          w_set_halt   = 1'b1;
          w_set_err    = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_is_addi) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_HALT;
          w_set_halt   = 1'b1;
          w_set_err    = !w_is_ebreak;
        end
      end
      S_WB:    w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_instret <= '0;
      r_halt    <= 1'b0;
      r_err     <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_WAIT) && i_inst_rsp_valid) begin
        r_inst <= i_inst_rdata;
      end
      if ((r_state == S_EXEC) && w_is_addi) begin
        r_waddr <= r_inst[11:7];
        r_wdata <= i_ex_result;
      end
      if (r_state == S_WB) begin
        r_pc      <= r_pc + 32'd4;
        r_instret <= r_instret + 32'd1;
      end
      if (w_set_halt) r_halt <= 1'b1;
      if (w_set_err)  r_err  <= 1'b1;
    end
  end

  // Reset state is FETCH, so the request is gated while reset is held.
  assign o_inst_req_valid = rst_n && (r_state == S_FETCH);
  assign o_inst_addr      = r_pc;
  assign o_rf_raddr       = r_inst[19:15];
  assign o_ex_op          = r_inst[6:0];
  assign o_ex_funct3      = r_inst[14:12];
  assign o_ex_imm         = r_inst[31:20];
  assign o_ex_src1        = i_rf_rdata;
  assign o_rf_wen         = (r_state == S_WB) && (r_waddr != 5'd0);
  assign o_rf_waddr       = r_waddr;
  assign o_rf_wdata       = r_wdata;
  assign o_pc             = r_pc;
  assign o_instret        = r_instret;
  assign o_halt           = r_halt;
  assign o_err            = r_err;

endmodule
